// File: rtl/parc_muldiv_seq_unit_pkg.sv
`default_nettype none
// ============================================================================
// parc_muldiv_seq_unit_pkg : shared muldiv function codes and decode helpers
// Revision: 1.0
// ============================================================================
package parc_muldiv_seq_unit_pkg;

    // Function codes shared with the X-stage control; 5-7 are reserved.
    typedef enum logic [2:0] {
        MULDIV_FN_MUL  = 3'd0,
        MULDIV_FN_DIV  = 3'd1,
        MULDIV_FN_DIVU = 3'd2,
        MULDIV_FN_REM  = 3'd3,
        MULDIV_FN_REMU = 3'd4
    } muldiv_fn_e;

    // Reserved codes fall through to multiply.
    function automatic logic fn_is_div(input logic [2:0] fn);
        return (fn == MULDIV_FN_DIV)  || (fn == MULDIV_FN_DIVU) ||
               (fn == MULDIV_FN_REM)  || (fn == MULDIV_FN_REMU);
    endfunction

    function automatic logic fn_is_unsigned(input logic [2:0] fn);
        return (fn == MULDIV_FN_DIVU) || (fn == MULDIV_FN_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/parc_muldiv_seq_dpath.sv
`default_nettype none
// ============================================================================
// parc_muldiv_seq_dpath : shift-add multiplier / restoring divider datapath
// Revision: 1.0
// ============================================================================
module parc_muldiv_seq_dpath
    import parc_muldiv_seq_unit_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               last,
    input  logic [2:0]         fn,
    input  logic [NBITS-1:0]   a,
    input  logic [NBITS-1:0]   b,
    output logic [2*NBITS-1:0] result
);

    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [2*NBITS-1:0] r_acc;
    logic [2*NBITS-1:0] r_mcand;
    logic [NBITS-1:0]   r_mplier;
    logic [2*NBITS-1:0] r_rq;
    logic [NBITS-1:0]   r_divisor;
    logic [2*NBITS-1:0] r_result;

    logic               w_sign_a;
    logic               w_sign_b;
    logic [NBITS-1:0]   w_abs_a;
    logic [NBITS-1:0]   w_abs_b;
    logic [2*NBITS-1:0] w_acc_next;
    logic [2*NBITS:0]   w_shift;
    logic [NBITS:0]     w_diff;
    logic [2*NBITS-1:0] w_rq_next;
    logic [NBITS-1:0]   w_quot_fix;
    logic [NBITS-1:0]   w_rem_fix;
    logic [2*NBITS-1:0] w_prod_fix;

    // Sign-magnitude operation: signed functions work on magnitudes.
    assign w_sign_a = !fn_is_unsigned(fn) && a[NBITS-1];
    assign w_sign_b = !fn_is_unsigned(fn) && b[NBITS-1];
    assign w_abs_a  = w_sign_a ? -a : a;
    assign w_abs_b  = w_sign_b ? -b : b;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // The shifted partial remainder needs one extra bit for the trial subtract.
    assign w_shift   = {r_rq, 1'b0};
    assign w_diff    = w_shift[2*NBITS:NBITS] - {1'b0, r_divisor};
    assign w_rq_next = w_diff[NBITS] ? w_shift[2*NBITS-1:0]
                                     : {w_diff[NBITS-1:0], w_shift[NBITS-1:1], 1'b1};

    assign w_quot_fix = r_neg_res ? -w_rq_next[NBITS-1:0] : w_rq_next[NBITS-1:0];
    assign w_rem_fix  = r_neg_rem ? -w_rq_next[2*NBITS-1:NBITS]
                                  : w_rq_next[2*NBITS-1:NBITS];
    assign w_prod_fix = r_neg_res ? -w_acc_next : w_acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rq      <= '0;
            r_divisor <= '0;
            r_result  <= '0;
        end else if (load) begin
            r_is_div  <= fn_is_div(fn);
            r_neg_res <= w_sign_a ^ w_sign_b;
            r_neg_rem <= w_sign_a;
            r_acc     <= '0;
            r_mcand   <= {{NBITS{1'b0}}, w_abs_a};
            r_mplier  <= w_abs_b;
            r_rq      <= {{NBITS{1'b0}}, w_abs_a};
            r_divisor <= w_abs_b;
        end else if (step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_rq     <= w_rq_next;
            if (last) begin
                r_result <= r_is_div ? {w_rem_fix, w_quot_fix} : w_prod_fix;
            end
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: rtl/parc_muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
// parc_muldiv_seq_unit : iterative 32-bit mul/div unit with val/rdy ports
// Revision: 1.0
// ============================================================================
module parc_muldiv_seq_unit
    import parc_muldiv_seq_unit_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         muldivreq_msg_fn,
    input  logic [NBITS-1:0]   muldivreq_msg_a,
    input  logic [NBITS-1:0]   muldivreq_msg_b,
    input  logic               muldivreq_val,
    output logic               muldivreq_rdy,
    output logic [2*NBITS-1:0] muldivresp_msg_result,
    output logic               muldivresp_val,
    input  logic               muldivresp_rdy
);

    localparam int              c_CNT_W   = $clog2(NBITS);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(NBITS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_count;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_count <= c_CNT_MAX;
            end else if (w_step) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (muldivreq_val)               w_state_next = c_ST_CALC;
            c_ST_CALC: if (r_count == '0)               w_state_next = c_ST_DONE;
            c_ST_DONE: if (muldivresp_rdy)              w_state_next = c_ST_IDLE;
            default:                                    w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        muldivreq_rdy  = (r_state == c_ST_IDLE);
        muldivresp_val = (r_state == c_ST_DONE);
        w_load         = muldivreq_rdy && muldivreq_val;
        w_step         = (r_state == c_ST_CALC);
        w_last         = w_step && (r_count == '0);
    end

    parc_muldiv_seq_dpath #(
        .NBITS (NBITS)
    ) u_dpath (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .step   (w_step),
        .last   (w_last),
        .fn     (muldivreq_msg_fn),
        .a      (muldivreq_msg_a),
        .b      (muldivreq_msg_b),
        .result (muldivresp_msg_result)
    );

endmodule
`default_nettype wire

// File: tb/tb_parc_muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
// tb_parc_muldiv_seq_unit : scoreboard bench for the iterative mul/div unit
// Revision: 1.0
// ============================================================================
module tb_parc_muldiv_seq_unit;
    import parc_muldiv_seq_unit_pkg::*;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  fn = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic [63:0] result;
    logic        resp_val;
    logic        resp_rdy = 1'b1;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    vec_t        vecs[13];

    always #5 clk = ~clk;

    parc_muldiv_seq_unit dut (
        .clk                   (clk),
        .reset                 (reset),
        .muldivreq_msg_fn      (fn),
        .muldivreq_msg_a       (a),
        .muldivreq_msg_b       (b),
        .muldivreq_val         (req_val),
        .muldivreq_rdy         (req_rdy),
        .muldivresp_msg_result (result),
        .muldivresp_val        (resp_val),
        .muldivresp_rdy        (resp_rdy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] f, input logic [31:0] x,
                                          input logic [31:0] y);
        logic signed [63:0] px;
        logic signed [63:0] py;
        logic [63:0]        prod;
        int                 sx;
        int                 sy;
        logic [31:0]        q;
        logic [31:0]        r;
        case (f)
            MULDIV_FN_DIVU, MULDIV_FN_REMU: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            MULDIV_FN_DIV, MULDIV_FN_REM: begin
                sx = x;
                sy = y;
                if (y == 0) begin
                    q = x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
                    r = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = 32'h0;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                end
                return {r, q};
            end
            default: begin
                px   = {{32{x[31]}}, x};
                py   = {{32{y[31]}}, y};
                prod = px * py;
                return prod;
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the unit to be ready, then presents one request for one edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e, input bit push, input bit bp);
        int n = 0;
        while (!req_rdy && n < 300) begin
            if (bp) resp_rdy = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        if (!req_rdy) begin
            errors++;
            checks++;
            $display("FAIL req_rdy_timeout actual=0 required=1");
        end
        fn      = f;
        a       = x;
        b       = y;
        req_val = 1'b1;
        if (push) sb.push_back(e);
        tick();
        req_val = 1'b0;
        a       = $urandom;
        b       = $urandom;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand(input bit divisor);
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 20);
            1: return -($urandom_range(1, 20));
            2: case ($urandom_range(0, 4))
                   0: return 32'h0;
                   1: return 32'h1;
                   2: return 32'hFFFF_FFFF;
                   3: return 32'h8000_0000;
                   default: return 32'h7FFF_FFFF;
               endcase
            default: return divisor ? 32'($urandom_range(1, 65535)) : $urandom;
        endcase
    endfunction

    // Scoreboard monitor: the handshake completes on the following rising edge.
    always @(negedge clk) begin
        if (!reset && resp_val && resp_rdy) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_response actual=%h required=none", result);
            end else begin
                check("response", result, sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [2:0]  rf;
        logic [31:0] rx;
        logic [31:0] ry;

        vecs[0]  = '{MULDIV_FN_MUL,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1]  = '{MULDIV_FN_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[2]  = '{MULDIV_FN_DIVU, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003};
        vecs[3]  = '{MULDIV_FN_REMU, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003};
        vecs[4]  = '{MULDIV_FN_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[5]  = '{MULDIV_FN_DIVU, 32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF};
        vecs[6]  = '{MULDIV_FN_DIV,  32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_0000_0001};
        vecs[7]  = '{MULDIV_FN_REM,  32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF};
        vecs[8]  = '{MULDIV_FN_MUL,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[9]  = '{MULDIV_FN_REM,  32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[10] = '{MULDIV_FN_DIVU, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_7FFF_FFFF};
        vecs[11] = '{3'd7,           32'h0000_0006, 32'h0000_0007, 64'h0000_0000_0000_002A};
        vecs[12] = '{MULDIV_FN_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};

        reset = 1'b1;
        repeat (3) tick();
        check("reset_req_rdy",  64'(req_rdy),  64'd1);
        check("reset_resp_val", 64'(resp_val), 64'd0);
        check("reset_result",   result,        64'd0);
        reset = 1'b0;
        tick();

        // First vector also measures accept-to-response latency.
        issue(vecs[0].f, vecs[0].x, vecs[0].y, vecs[0].e, 1'b1, 1'b0);
        lat = 0;
        while (!resp_val && lat < 40) begin
            tick();
            lat++;
        end
        check("mul_latency", 64'(lat), 64'd32);
        for (int i = 1; i < 13; i++) begin
            issue(vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].e, 1'b1, 1'b0);
        end
        drain("directed_drain");

        // Backpressure in DONE, then an immediate second op.
        resp_rdy = 1'b0;
        issue(MULDIV_FN_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 1'b1, 1'b0);
        lat = 0;
        while (!resp_val && lat < 40) begin
            tick();
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd32);
        for (int i = 0; i < 10; i++) begin
            check("bp_result",   result,         64'h0000_0001_0000_0003);
            check("bp_resp_val", 64'(resp_val),  64'd1);
            check("bp_req_rdy",  64'(req_rdy),   64'd0);
            tick();
        end
        resp_rdy = 1'b1;
        tick();
        check("bp_release_req_rdy", 64'(req_rdy), 64'd1);
        issue(MULDIV_FN_REMU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 1'b1, 1'b0);
        drain("b2b_drain");

        // Reset during CALC iteration 15 aborts the operation.
        issue(MULDIV_FN_MUL, 32'h1234_5678, 32'd9, 64'd0, 1'b0, 1'b0);
        repeat (14) tick();
        reset = 1'b1;
        tick();
        check("abort_req_rdy",  64'(req_rdy),  64'd1);
        check("abort_resp_val", 64'(resp_val), 64'd0);
        check("abort_result",   result,        64'd0);
        reset = 1'b0;
        issue(MULDIV_FN_MUL, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 1'b1, 1'b0);
        drain("abort_drain");

        // Random operations against the reference model with random backpressure.
        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom_range(0, 4));
            rx = pick_operand(1'b0);
            ry = pick_operand(1'b1);
            issue(rf, rx, ry, model(rf, rx, ry), 1'b1, 1'b1);
        end
        resp_rdy = 1'b1;
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
